// File: rtl/pe_comp_responder_pkg.sv
// Shared router packet layout, info codes and responder state type for the
// PE-side computation control endpoint.
package pe_comp_responder_pkg;

    localparam int ROUTER_WIDTH    = 36;
    localparam int PE_LAYER_NO_BUS = 4;

    localparam int INFO_MSB = 35;
    localparam int INFO_LSB = 32;
    localparam int ADDR_MSB = 31;
    localparam int ADDR_LSB = 16;
    localparam int DATA_MSB = 15;
    localparam int DATA_LSB = 0;

    localparam logic [3:0] ROUTER_INFO_CONFIG        = 4'd1;
    localparam logic [3:0] ROUTER_INFO_READ          = 4'd2;
    localparam logic [3:0] ROUTER_INFO_CALC          = 4'd3;
    localparam logic [3:0] ROUTER_INFO_FIN_BROADCAST = 4'd4;
    localparam logic [3:0] ROUTER_INFO_FIN_COMP      = 4'd5;
    localparam logic [3:0] ROUTER_INFO_UV            = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_BCAST_TX,
        ST_BCAST_WAIT,
        ST_COMP,
        ST_COMP_TX,
        ST_COMP_WAIT
    } resp_state_t;

    function automatic logic [ROUTER_WIDTH-1:0] make_packet(
        input logic [3:0]  info,
        input logic [15:0] addr,
        input logic [15:0] data
    );
        return {info, addr, data};
    endfunction

endpackage

// File: rtl/pe_comp_responder_if.sv
// LOCAL router port bundle: incoming packet stream and outgoing transmit path.
interface pe_comp_responder_if;
    import pe_comp_responder_pkg::*;

    logic                    in_data_valid;
    logic [ROUTER_WIDTH-1:0] in_data;
    logic                    tx_rdy;
    logic                    tx_en;
    logic [ROUTER_WIDTH-1:0] tx_data;

    modport master (
        output in_data_valid,
        output in_data,
        output tx_rdy,
        input  tx_en,
        input  tx_data
    );

    modport slave (
        input  in_data_valid,
        input  in_data,
        input  tx_rdy,
        output tx_en,
        output tx_data
    );

endinterface

// File: rtl/pe_fin_packer.sv
// Combinational FIN packet builder: chosen info code, addr 0, PE_ID as data.
module pe_fin_packer
    import pe_comp_responder_pkg::*;
#(
    parameter int PE_ID = 0
) (
    input  logic [3:0]              info,
    output logic [ROUTER_WIDTH-1:0] packet
);

    assign packet = make_packet(info, 16'h0000, 16'(PE_ID));

endmodule

// File: rtl/pe_comp_responder.sv
// PE endpoint of the root computation protocol: forwards CONFIG writes,
// sequences per-layer broadcast/compute phases and reports FIN packets.
module pe_comp_responder
    import pe_comp_responder_pkg::*;
#(
    parameter int PE_ID   = 0,
    parameter int LAYER_W = PE_LAYER_NO_BUS
) (
    input  logic               clk,
    input  logic               rst,
    pe_comp_responder_if.slave router,
    output logic               cfg_wr_en,
    output logic [15:0]        cfg_addr,
    output logic [15:0]        cfg_data,
    output logic               bcast_start,
    input  logic               bcast_done,
    output logic               comp_start,
    input  logic               comp_done,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               busy,
    output logic               calc_done,
    output logic               proto_err
);

    resp_state_t         state;
    resp_state_t         state_next;
    logic [LAYER_W-1:0]  layer_no;
    logic [LAYER_W-1:0]  layer_last;
    logic [LAYER_W-1:0]  idx_next;
    logic                bcast_start_next;
    logic                comp_start_next;
    logic                calc_done_next;
    logic                err_set;
    logic                tx_fire;
    logic [3:0]          tx_info;
    logic [ROUTER_WIDTH-1:0] fin_packet;

    logic [3:0]  pkt_info;
    logic [15:0] pkt_addr;
    logic [15:0] pkt_data;
    logic        is_config;
    logic        is_calc;
    logic        is_fin_bcast;
    logic        is_fin_comp;

    assign pkt_info = router.in_data[INFO_MSB:INFO_LSB];
    assign pkt_addr = router.in_data[ADDR_MSB:ADDR_LSB];
    assign pkt_data = router.in_data[DATA_MSB:DATA_LSB];

    assign is_config    = router.in_data_valid && (pkt_info == ROUTER_INFO_CONFIG);
    assign is_calc      = router.in_data_valid && (pkt_info == ROUTER_INFO_CALC);
    assign is_fin_bcast = router.in_data_valid && (pkt_info == ROUTER_INFO_FIN_BROADCAST);
    assign is_fin_comp  = router.in_data_valid && (pkt_info == ROUTER_INFO_FIN_COMP);

    // layer_no == 0 wraps to a full 2^LAYER_W layers through this subtraction
    assign layer_last = layer_no - LAYER_W'(1);

    always_comb begin
        state_next       = state;
        idx_next         = layer_idx;
        bcast_start_next = 1'b0;
        comp_start_next  = 1'b0;
        calc_done_next   = 1'b0;
        tx_fire          = 1'b0;
        tx_info          = ROUTER_INFO_FIN_BROADCAST;

        case (state)
            ST_IDLE: begin
                if (is_calc) begin
                    state_next       = ST_BCAST;
                    idx_next         = '0;
                    bcast_start_next = 1'b1;
                end
            end
            ST_BCAST: begin
                if (bcast_done) begin
                    if (router.tx_rdy) begin
                        tx_fire    = 1'b1;
                        state_next = ST_BCAST_WAIT;
                    end else begin
                        state_next = ST_BCAST_TX;
                    end
                end
            end
            ST_BCAST_TX: begin
                if (router.tx_rdy) begin
                    tx_fire    = 1'b1;
                    state_next = ST_BCAST_WAIT;
                end
            end
            ST_BCAST_WAIT: begin
                if (is_fin_bcast) begin
                    state_next      = ST_COMP;
                    comp_start_next = 1'b1;
                end
            end
            ST_COMP: begin
                tx_info = ROUTER_INFO_FIN_COMP;
                if (comp_done) begin
                    if (router.tx_rdy) begin
                        tx_fire    = 1'b1;
                        state_next = ST_COMP_WAIT;
                    end else begin
                        state_next = ST_COMP_TX;
                    end
                end
            end
            ST_COMP_TX: begin
                tx_info = ROUTER_INFO_FIN_COMP;
                if (router.tx_rdy) begin
                    tx_fire    = 1'b1;
                    state_next = ST_COMP_WAIT;
                end
            end
            ST_COMP_WAIT: begin
                if (is_fin_comp) begin
                    if (layer_idx == layer_last) begin
                        state_next     = ST_IDLE;
                        idx_next       = '0;
                        calc_done_next = 1'b1;
                    end else begin
                        state_next       = ST_BCAST;
                        idx_next         = layer_idx + LAYER_W'(1);
                        bcast_start_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        err_set = (is_calc      && (state != ST_IDLE))       ||
                  (is_fin_bcast && (state != ST_BCAST_WAIT)) ||
                  (is_fin_comp  && (state != ST_COMP_WAIT))  ||
                  (bcast_done   && (state != ST_BCAST))      ||
                  (comp_done    && (state != ST_COMP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            layer_idx   <= '0;
            bcast_start <= 1'b0;
            comp_start  <= 1'b0;
            calc_done   <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            state       <= state_next;
            layer_idx   <= idx_next;
            bcast_start <= bcast_start_next;
            comp_start  <= comp_start_next;
            calc_done   <= calc_done_next;
            proto_err   <= proto_err | err_set;
        end
    end

    // CONFIG writes are accepted in every state, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_wr_en <= 1'b0;
            cfg_addr  <= '0;
            cfg_data  <= '0;
            layer_no  <= '0;
        end else begin
            cfg_wr_en <= is_config;
            if (is_config) begin
                cfg_addr <= pkt_addr;
                cfg_data <= pkt_data;
                if (pkt_addr == 16'h0000) begin
                    layer_no <= pkt_data[LAYER_W-1:0];
                end
            end
        end
    end

    pe_fin_packer #(
        .PE_ID (PE_ID)
    ) u_fin_packer (
        .info   (tx_info),
        .packet (fin_packet)
    );

    assign busy           = (state != ST_IDLE);
    assign router.tx_en   = tx_fire && !rst;
    assign router.tx_data = router.tx_en ? fin_packet : '0;

endmodule

// File: tb/tb_pe_comp_responder.sv
// Directed self-checking bench for pe_comp_responder with hand-computed packets.
module tb_pe_comp_responder;
    import pe_comp_responder_pkg::*;

    localparam int PE_ID   = 5;
    localparam int LAYER_W = 4;
    localparam logic [35:0] FIN_B_PKT = 36'h4_0000_0005;
    localparam logic [35:0] FIN_C_PKT = 36'h5_0000_0005;

    logic               clk;
    logic               rst;
    logic               cfg_wr_en;
    logic [15:0]        cfg_addr;
    logic [15:0]        cfg_data;
    logic               bcast_start;
    logic               bcast_done;
    logic               comp_start;
    logic               comp_done;
    logic [LAYER_W-1:0] layer_idx;
    logic               busy;
    logic               calc_done;
    logic               proto_err;

    int vectors     = 0;
    int miscompares = 0;
    int n_bcast     = 0;
    int n_comp      = 0;
    int n_done      = 0;

    pe_comp_responder_if router_bus ();

    pe_comp_responder #(
        .PE_ID   (PE_ID),
        .LAYER_W (LAYER_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .router      (router_bus.slave),
        .cfg_wr_en   (cfg_wr_en),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .bcast_start (bcast_start),
        .bcast_done  (bcast_done),
        .comp_start  (comp_start),
        .comp_done   (comp_done),
        .layer_idx   (layer_idx),
        .busy        (busy),
        .calc_done   (calc_done),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bcast_start) n_bcast++;
        if (comp_start)  n_comp++;
        if (calc_done)   n_done++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [35:0] observed, input logic [35:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Present one packet for a single cycle; returns at the following negedge
    task automatic send_pkt(input logic [3:0] info, input logic [15:0] addr, input logic [15:0] data);
        router_bus.in_data_valid = 1'b1;
        router_bus.in_data       = {info, addr, data};
        @(negedge clk);
        router_bus.in_data_valid = 1'b0;
        router_bus.in_data       = '0;
    endtask

    // Runs one layer starting on the bcast_start cycle, ending after root FIN_COMP
    task automatic run_layer();
        bcast_done = 1'b1;
        @(negedge clk);
        bcast_done = 1'b0;
        send_pkt(ROUTER_INFO_FIN_BROADCAST, 16'h0, 16'h0);
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        send_pkt(ROUTER_INFO_FIN_COMP, 16'h0, 16'h0);
    endtask

    initial begin
        int b0, c0, d0;
        rst                      = 1'b1;
        bcast_done               = 1'b0;
        comp_done                = 1'b0;
        router_bus.in_data_valid = 1'b0;
        router_bus.in_data       = '0;
        router_bus.tx_rdy        = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("reset_busy",      36'(busy),         36'd0);
        check("reset_layer_idx", 36'(layer_idx),    36'd0);
        check("reset_proto_err", 36'(proto_err),    36'd0);
        check("reset_tx_en",     36'(router_bus.tx_en), 36'd0);
        check("reset_cfg_wr_en", 36'(cfg_wr_en),    36'd0);
        check("reset_layer_no",  36'(dut.layer_no), 36'd0);
        check("reset_state",     36'(dut.state),    36'(ST_IDLE));

        // Single layer
        send_pkt(ROUTER_INFO_CONFIG, 16'h0000, 16'h0001);
        check("cfg0_wr_en",    36'(cfg_wr_en),    36'd1);
        check("cfg0_data",     36'(cfg_data),     36'h1);
        check("cfg0_layer_no", 36'(dut.layer_no), 36'd1);
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        check("calc_bcast_start", 36'(bcast_start), 36'd1);
        check("calc_busy",        36'(busy),        36'd1);
        @(negedge clk);
        check("bcast_start_pulse", 36'(bcast_start), 36'd0);
        bcast_done = 1'b1;
        #1;
        check("fin_b_tx_en",   36'(router_bus.tx_en), 36'd1);
        check("fin_b_tx_data", router_bus.tx_data,    FIN_B_PKT);
        @(negedge clk);
        bcast_done = 1'b0;
        #1;
        check("fin_b_tx_once", 36'(router_bus.tx_en), 36'd0);
        send_pkt(ROUTER_INFO_FIN_BROADCAST, 16'h0, 16'h0);
        check("comp_start", 36'(comp_start), 36'd1);
        comp_done = 1'b1;
        #1;
        check("fin_c_tx_en",   36'(router_bus.tx_en), 36'd1);
        check("fin_c_tx_data", router_bus.tx_data,    FIN_C_PKT);
        @(negedge clk);
        comp_done = 1'b0;
        send_pkt(ROUTER_INFO_FIN_COMP, 16'h0, 16'h0);
        check("l1_calc_done", 36'(calc_done), 36'd1);
        check("l1_busy",      36'(busy),      36'd0);
        check("l1_layer_idx", 36'(layer_idx), 36'd0);
        @(negedge clk);
        check("calc_done_pulse", 36'(calc_done), 36'd0);

        // Three layers
        send_pkt(ROUTER_INFO_CONFIG, 16'h0000, 16'h0003);
        b0 = n_bcast; c0 = n_comp; d0 = n_done;
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            check("l3_layer_idx", 36'(layer_idx), 36'(i));
            run_layer();
            check("l3_next", {34'd0, calc_done, bcast_start}, (i == 2) ? 36'b10 : 36'b01);
        end
        @(negedge clk);
        check("l3_bcast_count", 36'(n_bcast - b0), 36'd3);
        check("l3_comp_count",  36'(n_comp - c0),  36'd3);
        check("l3_done_count",  36'(n_done - d0),  36'd1);
        check("l3_idle",        36'(busy),         36'd0);

        // Stall in COMP_TX, then CONFIG in COMP_WAIT
        send_pkt(ROUTER_INFO_CONFIG, 16'h0000, 16'h0001);
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        bcast_done = 1'b1;
        @(negedge clk);
        bcast_done = 1'b0;
        send_pkt(ROUTER_INFO_FIN_BROADCAST, 16'h0, 16'h0);
        router_bus.tx_rdy = 1'b0;
        comp_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_tx_en", 36'(router_bus.tx_en), 36'd0);
            @(negedge clk);
            comp_done = 1'b0;
        end
        check("stall_state", 36'(dut.state), 36'(ST_COMP_TX));
        router_bus.tx_rdy = 1'b1;
        #1;
        check("stall_release_tx_en", 36'(router_bus.tx_en), 36'd1);
        check("stall_release_data",  router_bus.tx_data,    FIN_C_PKT);
        @(negedge clk);
        #1;
        check("stall_single_tx", 36'(router_bus.tx_en), 36'd0);
        check("comp_wait_state", 36'(dut.state),        36'(ST_COMP_WAIT));
        @(negedge clk);
        send_pkt(ROUTER_INFO_CONFIG, 16'h0123, 16'hBEEF);
        check("busy_cfg_wr_en", 36'(cfg_wr_en),  36'd1);
        check("busy_cfg_addr",  36'(cfg_addr),   36'h0123);
        check("busy_cfg_data",  36'(cfg_data),   36'hBEEF);
        check("busy_cfg_state", 36'(dut.state),  36'(ST_COMP_WAIT));
        send_pkt(ROUTER_INFO_FIN_COMP, 16'h0, 16'h0);
        check("stall_calc_done", 36'(calc_done), 36'd1);
        check("no_err_yet",      36'(proto_err), 36'd0);

        // Protocol errors are ignored but flagged
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        send_pkt(ROUTER_INFO_FIN_COMP, 16'h0, 16'h0);
        check("err_fin_comp_flag",  36'(proto_err), 36'd1);
        check("err_fin_comp_state", 36'(dut.state), 36'(ST_BCAST));
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        check("err_calc_state", 36'(dut.state),   36'(ST_BCAST));
        check("err_calc_bcast", 36'(bcast_start), 36'd0);
        run_layer();
        check("err_run_done", 36'(calc_done), 36'd1);
        check("err_sticky",   36'(proto_err), 36'd1);

        // Reset while stalled in COMP_TX
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        bcast_done = 1'b1;
        @(negedge clk);
        bcast_done = 1'b0;
        send_pkt(ROUTER_INFO_FIN_BROADCAST, 16'h0, 16'h0);
        router_bus.tx_rdy = 1'b0;
        comp_done = 1'b1;
        @(negedge clk);
        comp_done = 1'b0;
        check("rst_pre_state", 36'(dut.state), 36'(ST_COMP_TX));
        rst = 1'b1;
        router_bus.tx_rdy = 1'b1;
        #1;
        check("rst_cycle_tx_en", 36'(router_bus.tx_en), 36'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_state",     36'(dut.state),         36'(ST_IDLE));
        check("rst_tx_en",     36'(router_bus.tx_en),  36'd0);
        check("rst_layer_no",  36'(dut.layer_no),      36'd0);
        check("rst_proto_err", 36'(proto_err),         36'd0);

        // layer_no = 0 runs a full 16 layers
        @(negedge clk);
        send_pkt(ROUTER_INFO_CALC, 16'h0, 16'h0);
        for (int i = 0; i < 16; i++) begin
            run_layer();
            check("wrap_next", {34'd0, calc_done, bcast_start}, (i == 15) ? 36'b10 : 36'b01);
        end
        check("wrap_proto_err", 36'(proto_err), 36'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
